// File: rtl/nv_dbb_axi_responder_if.sv
// DBB AXI-style bus bundle between the NVDLA core master port and a responder.
// No size/burst/resp signals; bursts are INCR of 32-bit words.
interface nv_dbb_axi_responder_if;
    logic        S_AXI_awvalid;
    logic        S_AXI_awready;
    logic [7:0]  S_AXI_awid;
    logic [3:0]  S_AXI_awlen;
    logic [31:0] S_AXI_awaddr;
    logic        S_AXI_wvalid;
    logic        S_AXI_wready;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wlast;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready;
    logic [7:0]  S_AXI_bid;
    logic        S_AXI_arvalid;
    logic        S_AXI_arready;
    logic [7:0]  S_AXI_arid;
    logic [3:0]  S_AXI_arlen;
    logic [31:0] S_AXI_araddr;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready;
    logic [7:0]  S_AXI_rid;
    logic        S_AXI_rlast;
    logic [31:0] S_AXI_rdata;

    modport slave (
        input  S_AXI_awvalid, S_AXI_awid, S_AXI_awlen, S_AXI_awaddr,
        output S_AXI_awready,
        input  S_AXI_wvalid, S_AXI_wdata, S_AXI_wstrb, S_AXI_wlast,
        output S_AXI_wready,
        input  S_AXI_bready,
        output S_AXI_bvalid, S_AXI_bid,
        input  S_AXI_arvalid, S_AXI_arid, S_AXI_arlen, S_AXI_araddr,
        output S_AXI_arready,
        input  S_AXI_rready,
        output S_AXI_rvalid, S_AXI_rid, S_AXI_rlast, S_AXI_rdata
    );

    modport master (
        output S_AXI_awvalid, S_AXI_awid, S_AXI_awlen, S_AXI_awaddr,
        input  S_AXI_awready,
        output S_AXI_wvalid, S_AXI_wdata, S_AXI_wstrb, S_AXI_wlast,
        input  S_AXI_wready,
        output S_AXI_bready,
        input  S_AXI_bvalid, S_AXI_bid,
        output S_AXI_arvalid, S_AXI_arid, S_AXI_arlen, S_AXI_araddr,
        input  S_AXI_arready,
        output S_AXI_rready,
        input  S_AXI_rvalid, S_AXI_rid, S_AXI_rlast, S_AXI_rdata
    );
endinterface

// File: rtl/nv_dbb_axi_responder.sv
// DBB responder: one AXI-style burst at a time served from an async-read RAM.
// Out-of-window beats are dropped/zeroed and counted.
module nv_dbb_axi_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    nv_dbb_axi_responder_if.slave       s,
    output logic                        err_wlast,
    output logic [15:0]                 oob_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t      state_q, state_d;
    logic        last_wr_q, last_wr_d;
    logic [7:0]  id_q, id_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] ptr_q, ptr_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] oob_q, oob_d;

    logic [31:0] mem_q [DEPTH];

    logic        awready, arready, wready, mem_we, oob_inc;
    logic [29:0] aw_word, ar_word, ld_word;
    logic        ptr_in, ld_in;
    logic [31:0] ld_data;

    assign aw_word = 30'((s.S_AXI_awaddr - BASE_ADDR) >> 2);
    assign ar_word = 30'((s.S_AXI_araddr - BASE_ADDR) >> 2);
    assign ptr_in  = ptr_q < 30'(DEPTH);
    // Beat 0 comes straight from the AR address; later beats from ptr.
    assign ld_word = (state_q == IDLE) ? ar_word : ptr_q;
    assign ld_in   = ld_word < 30'(DEPTH);
    assign ld_data = ld_in ? mem_q[ld_word[AW-1:0]] : 32'h0;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        mem_we    = 1'b0;
        oob_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ties alternate: the side not served last goes first.
                awready = s.S_AXI_awvalid &&
                          (!s.S_AXI_arvalid || !last_wr_q);
                arready = s.S_AXI_arvalid && !awready;
                if (awready) begin
                    id_d      = s.S_AXI_awid;
                    len_d     = s.S_AXI_awlen;
                    ptr_d     = aw_word;
                    cnt_d     = 4'd0;
                    last_wr_d = 1'b1;
                    state_d   = WDATA;
                end else if (arready) begin
                    id_d      = s.S_AXI_arid;
                    len_d     = s.S_AXI_arlen;
                    ptr_d     = ar_word + 30'd1;
                    cnt_d     = 4'd0;
                    last_wr_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = ld_data;
                    rlast_d   = (s.S_AXI_arlen == 4'd0);
                    oob_inc   = !ld_in;
                    state_d   = RDATA;
                end
            end
            WDATA: begin
                wready = 1'b1;
                if (s.S_AXI_wvalid) begin
                    mem_we  = ptr_in;
                    oob_inc = !ptr_in;
                    ptr_d   = ptr_q + 30'd1;
                    cnt_d   = cnt_q + 4'd1;
                    if (s.S_AXI_wlast != (cnt_q == len_q))
                        err_d = 1'b1;
                    if (cnt_q == len_q)
                        state_d = WRESP;
                end
            end
            WRESP: begin
                if (s.S_AXI_bready)
                    state_d = IDLE;
            end
            RDATA: begin
                if (rvalid_q && s.S_AXI_rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        rdata_d = ld_data;
                        rlast_d = (cnt_q + 4'd1 == len_q);
                        cnt_d   = cnt_q + 4'd1;
                        ptr_d   = ptr_q + 30'd1;
                        oob_inc = !ld_in;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        oob_d = (oob_inc && oob_q != 16'hFFFF) ? oob_q + 16'd1 : oob_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            id_q      <= 8'h0;
            len_q     <= 4'h0;
            cnt_q     <= 4'h0;
            ptr_q     <= 30'h0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            oob_q     <= 16'h0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            oob_q     <= oob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s.S_AXI_wstrb[b])
                    mem_q[ptr_q[AW-1:0]][8*b +: 8] <= s.S_AXI_wdata[8*b +: 8];
            end
        end
    end

    assign s.S_AXI_awready = awready;
    assign s.S_AXI_arready = arready;
    assign s.S_AXI_wready  = wready;
    assign s.S_AXI_bvalid  = (state_q == WRESP);
    assign s.S_AXI_bid     = id_q;
    assign s.S_AXI_rvalid  = rvalid_q;
    assign s.S_AXI_rid     = id_q;
    assign s.S_AXI_rlast   = rlast_q;
    assign s.S_AXI_rdata   = rdata_q;
    assign err_wlast       = err_q;
    assign oob_cnt         = oob_q;
endmodule

// File: tb/tb_nv_dbb_axi_responder.sv
// Directed bench for nv_dbb_axi_responder: bursts, arbitration, strobes,
// back-pressure, wlast errors, out-of-window beats and mid-burst reset.
module tb_nv_dbb_axi_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        err_wlast;
    logic [15:0] oob_cnt;
    int          checks = 0;
    int          errors = 0;

    nv_dbb_axi_responder_if bus ();

    nv_dbb_axi_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s         (bus),
        .err_wlast (err_wlast),
        .oob_cnt   (oob_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.S_AXI_awvalid = 1'b0;
        bus.S_AXI_awid    = 8'h0;
        bus.S_AXI_awlen   = 4'h0;
        bus.S_AXI_awaddr  = 32'h0;
        bus.S_AXI_wvalid  = 1'b0;
        bus.S_AXI_wdata   = 32'h0;
        bus.S_AXI_wstrb   = 4'h0;
        bus.S_AXI_wlast   = 1'b0;
        bus.S_AXI_bready  = 1'b0;
        bus.S_AXI_arvalid = 1'b0;
        bus.S_AXI_arid    = 8'h0;
        bus.S_AXI_arlen   = 4'h0;
        bus.S_AXI_araddr  = 32'h0;
        bus.S_AXI_rready  = 1'b0;
    endtask

    task automatic aw_hs(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
        bit got = 0;
        bus.S_AXI_awvalid = 1'b1;
        bus.S_AXI_awid    = id;
        bus.S_AXI_awaddr  = addr;
        bus.S_AXI_awlen   = len;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (bus.S_AXI_awready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL aw_handshake: awready=0 required=1 addr=%h", addr);
        end
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_awvalid = 1'b0;
    endtask

    task automatic ar_hs(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
        bit got = 0;
        bus.S_AXI_arvalid = 1'b1;
        bus.S_AXI_arid    = id;
        bus.S_AXI_araddr  = addr;
        bus.S_AXI_arlen   = len;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (bus.S_AXI_arready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ar_handshake: arready=0 required=1 addr=%h", addr);
        end
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_arvalid = 1'b0;
    endtask

    task automatic w_beats(input int len, input logic [31:0] d0,
                           input logic [3:0] strb, input int wlast_at);
        for (int i = 0; i <= len; i++) begin
            bit got = 0;
            bus.S_AXI_wvalid = 1'b1;
            bus.S_AXI_wdata  = d0 + 32'(i);
            bus.S_AXI_wstrb  = strb;
            bus.S_AXI_wlast  = (i == wlast_at);
            for (int t = 0; t < 20; t++) begin
                #1;
                if (bus.S_AXI_wready) begin
                    got = 1;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL w_beat%0d: wready=0 required=1", i);
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.S_AXI_wvalid = 1'b0;
        bus.S_AXI_wlast  = 1'b0;
        #1;
        checks++;
        if (bus.S_AXI_wready !== 1'b0 || bus.S_AXI_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL w_done: wready=%b bvalid=%b required 0/1",
                     bus.S_AXI_wready, bus.S_AXI_bvalid);
        end
    endtask

    task automatic b_resp(input logic [7:0] id);
        checks++;
        if (bus.S_AXI_bid !== id) begin
            errors++;
            $display("FAIL bid: got %h required %h", bus.S_AXI_bid, id);
        end
        bus.S_AXI_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_bready = 1'b0;
        #1;
        checks++;
        if (bus.S_AXI_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_done: bvalid=%b required 0", bus.S_AXI_bvalid);
        end
    endtask

    task automatic r_beats(input logic [7:0] id, input int len,
                           input logic [31:0] exp [16], input bit toggle);
        int          beat = 0;
        bit          hv = 0;
        logic [31:0] hd = 32'h0;
        logic        hl = 1'b0;
        for (int c = 0; c < 100 && beat <= len; c++) begin
            bus.S_AXI_rready = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            checks++;
            if (bus.S_AXI_rvalid !== 1'b1) begin
                errors++;
                $display("FAIL r_valid beat%0d: rvalid=%b required 1",
                         beat, bus.S_AXI_rvalid);
            end
            if (hv) begin
                checks++;
                if (bus.S_AXI_rdata !== hd || bus.S_AXI_rlast !== hl) begin
                    errors++;
                    $display("FAIL r_hold: rdata=%h rlast=%b required %h/%b",
                             bus.S_AXI_rdata, bus.S_AXI_rlast, hd, hl);
                end
            end
            if (bus.S_AXI_rready) begin
                checks++;
                if (bus.S_AXI_rdata !== exp[beat] ||
                    bus.S_AXI_rlast !== (beat == len) ||
                    bus.S_AXI_rid !== id) begin
                    errors++;
                    $display("FAIL r_beat%0d: rdata=%h rlast=%b rid=%h required %h/%b/%h",
                             beat, bus.S_AXI_rdata, bus.S_AXI_rlast,
                             bus.S_AXI_rid, exp[beat], beat == len, id);
                end
                beat++;
                hv = 0;
            end else begin
                hv = 1;
                hd = bus.S_AXI_rdata;
                hl = bus.S_AXI_rlast;
            end
            @(negedge clk);
        end
        bus.S_AXI_rready = 1'b0;
        #1;
        checks++;
        if (beat != len + 1 || bus.S_AXI_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_done: beats=%0d rvalid=%b required %0d/0",
                     beat, bus.S_AXI_rvalid, len + 1);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.S_AXI_awready !== 0 || bus.S_AXI_arready !== 0 ||
            bus.S_AXI_wready !== 0 || bus.S_AXI_bvalid !== 0 ||
            bus.S_AXI_rvalid !== 0 || bus.S_AXI_rlast !== 0 ||
            bus.S_AXI_bid !== 8'h0 || bus.S_AXI_rid !== 8'h0 ||
            bus.S_AXI_rdata !== 32'h0 || err_wlast !== 0 ||
            oob_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: rv=%b bv=%b rdata=%h err=%b oob=%h required all 0",
                     bus.S_AXI_rvalid, bus.S_AXI_bvalid, bus.S_AXI_rdata,
                     err_wlast, oob_cnt);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst();
        aw_hs(8'h3C, 32'h10, 4'd3);
        w_beats(3, 32'hA0, 4'hF, 3);
        b_resp(8'h3C);
    endtask

    task automatic test_read_burst();
        logic [31:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = 32'hA0 + 32'(i);
        ar_hs(8'h7E, 32'h10, 4'd3);
        r_beats(8'h7E, 3, exp, 1'b0);
    endtask

    task automatic test_arbitration();
        logic [31:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = 32'hA0;
        pulse_reset();
        bus.S_AXI_awvalid = 1'b1;
        bus.S_AXI_awid    = 8'd5;
        bus.S_AXI_awaddr  = 32'h20;
        bus.S_AXI_awlen   = 4'd0;
        bus.S_AXI_arvalid = 1'b1;
        bus.S_AXI_arid    = 8'd9;
        bus.S_AXI_araddr  = 32'h10;
        bus.S_AXI_arlen   = 4'd0;
        #1;
        checks++;
        if (bus.S_AXI_awready !== 1 || bus.S_AXI_arready !== 0) begin
            errors++;
            $display("FAIL tie_first: awready=%b arready=%b required 1/0",
                     bus.S_AXI_awready, bus.S_AXI_arready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_awvalid = 1'b0;
        #1;
        checks++;
        if (bus.S_AXI_arready !== 0) begin
            errors++;
            $display("FAIL busy_arready: got %b required 0",
                     bus.S_AXI_arready);
        end
        w_beats(0, 32'hB0, 4'hF, 0);
        b_resp(8'd5);
        bus.S_AXI_awvalid = 1'b1;
        bus.S_AXI_awid    = 8'd6;
        bus.S_AXI_awaddr  = 32'h24;
        #1;
        checks++;
        if (bus.S_AXI_awready !== 0 || bus.S_AXI_arready !== 1) begin
            errors++;
            $display("FAIL tie_second: awready=%b arready=%b required 0/1",
                     bus.S_AXI_awready, bus.S_AXI_arready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_arvalid = 1'b0;
        r_beats(8'd9, 0, exp, 1'b0);
        aw_hs(8'd6, 32'h24, 4'd0);
        w_beats(0, 32'hB1, 4'hF, 0);
        b_resp(8'd6);
    endtask

    task automatic test_strobe();
        logic [31:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = 32'h11FF33FF;
        aw_hs(8'h01, 32'h80, 4'd0);
        w_beats(0, 32'h11223344, 4'hF, 0);
        b_resp(8'h01);
        aw_hs(8'h02, 32'h80, 4'd0);
        w_beats(0, 32'hFFFFFFFF, 4'b0101, 0);
        b_resp(8'h02);
        ar_hs(8'h03, 32'h80, 4'd0);
        r_beats(8'h03, 0, exp, 1'b0);
    endtask

    task automatic test_rready_toggle();
        logic [31:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = 32'h100 + 32'(i);
        aw_hs(8'h10, 32'h40, 4'd7);
        w_beats(7, 32'h100, 4'hF, 7);
        b_resp(8'h10);
        ar_hs(8'h11, 32'h40, 4'd7);
        r_beats(8'h11, 7, exp, 1'b1);
    endtask

    task automatic test_err_wlast();
        checks++;
        if (err_wlast !== 1'b0) begin
            errors++;
            $display("FAIL err_before: got %b required 0", err_wlast);
        end
        aw_hs(8'h20, 32'h60, 4'd1);
        w_beats(1, 32'hC0, 4'hF, 0);
        checks++;
        if (err_wlast !== 1'b1) begin
            errors++;
            $display("FAIL err_wlast: got %b required 1", err_wlast);
        end
        b_resp(8'h20);
    endtask

    task automatic test_oob();
        logic [31:0] exp [16];
        for (int i = 0; i < 16; i++) exp[i] = 32'h0;
        exp[0] = 32'hD0;
        exp[1] = 32'hD1;
        checks++;
        if (oob_cnt !== 16'd0) begin
            errors++;
            $display("FAIL oob_before: got %0d required 0", oob_cnt);
        end
        aw_hs(8'h30, 32'h3F8, 4'd3);
        w_beats(3, 32'hD0, 4'hF, 3);
        b_resp(8'h30);
        checks++;
        if (oob_cnt !== 16'd2) begin
            errors++;
            $display("FAIL oob_write: got %0d required 2", oob_cnt);
        end
        ar_hs(8'h31, 32'h3F8, 4'd3);
        r_beats(8'h31, 3, exp, 1'b0);
        checks++;
        if (oob_cnt !== 16'd4) begin
            errors++;
            $display("FAIL oob_read: got %0d required 4", oob_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        ar_hs(8'h40, 32'h40, 4'd7);
        bus.S_AXI_rready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.S_AXI_rdata !== 32'h102 || bus.S_AXI_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_read: rdata=%h rvalid=%b required 102/1",
                     bus.S_AXI_rdata, bus.S_AXI_rvalid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.S_AXI_rvalid !== 1'b0 || bus.S_AXI_rlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: rvalid=%b rlast=%b required 0/0",
                     bus.S_AXI_rvalid, bus.S_AXI_rlast);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.S_AXI_rvalid !== 0 || err_wlast !== 0 || oob_cnt !== 0) begin
            errors++;
            $display("FAIL post_reset: rvalid=%b err=%b oob=%0d required 0",
                     bus.S_AXI_rvalid, err_wlast, oob_cnt);
        end
        bus.S_AXI_rready  = 1'b0;
        bus.S_AXI_awvalid = 1'b1;
        bus.S_AXI_awaddr  = 32'h0;
        #1;
        checks++;
        if (bus.S_AXI_awready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: awready=%b required 1",
                     bus.S_AXI_awready);
        end
        bus.S_AXI_awvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_arbitration();
        test_strobe();
        test_rready_toggle();
        test_err_wlast();
        test_oob();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
